// File: rtl/quiz_pkg.sv
// rtl/quiz_pkg.sv - shared types, player codes and joystick nibble decode for the quiz controller
package quiz_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ASK,
        ST_JUDGE,
        ST_RESULT,
        ST_WIN,
        ST_DONE
    } state_t;

    localparam logic [1:0] PLY_NONE = 2'd0;
    localparam logic [1:0] PLY_1    = 2'd1;
    localparam logic [1:0] PLY_2    = 2'd2;

    localparam int ANS_W = 4;

    // Active-low nibble: exactly one zero bit selects answer 1..4 (MSB is 1); anything else reads as 0.
    function automatic logic [ANS_W-1:0] decode_nibble(input logic [3:0] nib);
        logic [ANS_W-1:0] code;
        code = '0;
        case (nib)
            4'b0111: code = 4'd1;
            4'b1011: code = 4'd2;
            4'b1101: code = 4'd3;
            4'b1110: code = 4'd4;
            default: code = '0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/press_debounce.sv
// rtl/press_debounce.sv - per-player stability counter producing a single accept pulse per press
module press_debounce
    import quiz_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       nibble,
    input  logic             en,
    output logic             accept,
    output logic [ANS_W-1:0] choice
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC);

    logic [ANS_W-1:0] code;
    logic [ANS_W-1:0] code_q, code_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             armed_q, armed_d;
    logic             accept_q, accept_d;
    logic [ANS_W-1:0] choice_q, choice_d;
    logic             same;
    logic             hit;

    always_comb begin
        code     = decode_nibble(nibble);
        same     = (code == code_q);
        code_d   = code;
        cnt_d    = '0;
        if (code != '0) begin
            if (!same)
                cnt_d = CW'(1);
            else if (cnt_q == CNT_MAX)
                cnt_d = cnt_q;
            else
                cnt_d = cnt_q + CW'(1);
        end
        // Fire only on the cycle the count first reaches the threshold, so a held press cannot re-fire.
        hit      = en && armed_q && (code != '0) && (cnt_d == CNT_MAX)
                   && !(same && (cnt_q == CNT_MAX));
        armed_d  = hit ? 1'b0 : ((code == '0) ? 1'b1 : armed_q);
        accept_d = hit;
        choice_d = hit ? code : choice_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            code_q   <= '0;
            cnt_q    <= '0;
            armed_q  <= 1'b1;
            accept_q <= 1'b0;
            choice_q <= '0;
        end else begin
            code_q   <= code_d;
            cnt_q    <= cnt_d;
            armed_q  <= armed_d;
            accept_q <= accept_d;
            choice_q <= choice_d;
        end
    end

    assign accept = accept_q;
    assign choice = choice_q;

endmodule

// File: rtl/quiz_round_ctrl.sv
// rtl/quiz_round_ctrl.sv - two-player quiz round sequencer with buzzer arbitration, scoring and win beep
module quiz_round_ctrl
    import quiz_pkg::*;
#(
    parameter int NUM_Q        = 10,
    parameter int WIN_SCORE    = 5,
    parameter int DEBOUNCE_CYC = 4,
    parameter int SHOW_CYC     = 8,
    parameter int BEEP_CYC     = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] in_hex_joy,
    input  logic [3:0] ans_key,
    output logic [3:0] q_index,
    output logic [2:0] score_p1,
    output logic [2:0] score_p2,
    output logic [1:0] round_winner,
    output logic       lock_p1,
    output logic       lock_p2,
    output logic       toggle_beep,
    output logic       game_over
);

    localparam int TMAX = (SHOW_CYC > BEEP_CYC) ? SHOW_CYC : BEEP_CYC;
    localparam int TW   = $clog2(TMAX + 1);

    state_t           state_q, state_d;
    logic [3:0]       q_q, q_d;
    logic [2:0]       s1_q, s1_d, s2_q, s2_d;
    logic [2:0]       s1_inc, s2_inc;
    logic [1:0]       win_q, win_d;
    logic             l1_q, l1_d, l2_q, l2_d;
    logic             beep_q, beep_d;
    logic             over_q, over_d;
    logic             prio_q, prio_d;
    logic [1:0]       sel_q, sel_d;
    logic [ANS_W-1:0] selc_q, selc_d;
    logic [TW-1:0]    timer_q, timer_d;

    logic             en1, en2, acc1, acc2;
    logic [ANS_W-1:0] ch1, ch2;

    assign en1 = (state_q == ST_ASK) && !l1_q;
    assign en2 = (state_q == ST_ASK) && !l2_q;

    press_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_p1 (
        .clk    (clk),
        .reset  (reset),
        .nibble (in_hex_joy[7:4]),
        .en     (en1),
        .accept (acc1),
        .choice (ch1)
    );

    press_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_p2 (
        .clk    (clk),
        .reset  (reset),
        .nibble (in_hex_joy[3:0]),
        .en     (en2),
        .accept (acc2),
        .choice (ch2)
    );

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        win_d   = win_q;
        l1_d    = l1_q;
        l2_d    = l2_q;
        prio_d  = prio_q;
        sel_d   = sel_q;
        selc_d  = selc_q;
        timer_d = '0;
        s1_inc  = s1_q + 3'd1;
        s2_inc  = s2_q + 3'd1;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_ASK;
                    q_d     = '0;
                    s1_d    = '0;
                    s2_d    = '0;
                    l1_d    = 1'b0;
                    l2_d    = 1'b0;
                    win_d   = PLY_NONE;
                end
            end
            ST_ASK: begin
                // prio_q set means P1 won the last scored round, so P2 wins a tie.
                if (acc1 && (!acc2 || !prio_q)) begin
                    sel_d   = PLY_1;
                    selc_d  = ch1;
                    state_d = ST_JUDGE;
                end else if (acc2) begin
                    sel_d   = PLY_2;
                    selc_d  = ch2;
                    state_d = ST_JUDGE;
                end
            end
            ST_JUDGE: begin
                if (selc_q == ans_key) begin
                    if (sel_q == PLY_1) begin
                        s1_d    = s1_inc;
                        prio_d  = 1'b1;
                        state_d = (s1_inc == 3'(WIN_SCORE)) ? ST_WIN : ST_RESULT;
                    end else begin
                        s2_d    = s2_inc;
                        prio_d  = 1'b0;
                        state_d = (s2_inc == 3'(WIN_SCORE)) ? ST_WIN : ST_RESULT;
                    end
                    win_d = (state_d == ST_RESULT) ? sel_q : PLY_NONE;
                end else begin
                    if (sel_q == PLY_1)
                        l1_d = 1'b1;
                    else
                        l2_d = 1'b1;
                    state_d = (l1_d && l2_d) ? ST_RESULT : ST_ASK;
                    win_d   = PLY_NONE;
                end
            end
            ST_RESULT: begin
                if (timer_q == TW'(SHOW_CYC - 1)) begin
                    l1_d  = 1'b0;
                    l2_d  = 1'b0;
                    win_d = PLY_NONE;
                    if (q_q == 4'(NUM_Q - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        q_d     = q_q + 4'd1;
                        state_d = ST_ASK;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_WIN: begin
                if (timer_q == TW'(BEEP_CYC - 1))
                    state_d = ST_DONE;
                else
                    timer_d = timer_q + TW'(1);
            end
            default: state_d = ST_IDLE;
        endcase

        beep_d = (state_d == ST_WIN);
        over_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            win_q   <= PLY_NONE;
            l1_q    <= 1'b0;
            l2_q    <= 1'b0;
            beep_q  <= 1'b0;
            over_q  <= 1'b0;
            prio_q  <= 1'b0;
            sel_q   <= PLY_NONE;
            selc_q  <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            win_q   <= win_d;
            l1_q    <= l1_d;
            l2_q    <= l2_d;
            beep_q  <= beep_d;
            over_q  <= over_d;
            prio_q  <= prio_d;
            sel_q   <= sel_d;
            selc_q  <= selc_d;
            timer_q <= timer_d;
        end
    end

    assign q_index      = q_q;
    assign score_p1     = s1_q;
    assign score_p2     = s2_q;
    assign round_winner = win_q;
    assign lock_p1      = l1_q;
    assign lock_p2      = l2_q;
    assign toggle_beep  = beep_q;
    assign game_over    = over_q;

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// tb/tb_quiz_round_ctrl.sv - directed self-checking bench for quiz_round_ctrl
module tb_quiz_round_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] in_hex_joy;
    logic [3:0] ans_key;
    logic [3:0] q_index;
    logic [2:0] score_p1, score_p2;
    logic [1:0] round_winner;
    logic       lock_p1, lock_p2, toggle_beep, game_over;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    quiz_round_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_hex_joy   (in_hex_joy),
        .ans_key      (ans_key),
        .q_index      (q_index),
        .score_p1     (score_p1),
        .score_p2     (score_p2),
        .round_winner (round_winner),
        .lock_p1      (lock_p1),
        .lock_p2      (lock_p2),
        .toggle_beep  (toggle_beep),
        .game_over    (game_over)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {16'd0, q_index, score_p1, score_p2, round_winner,
                  lock_p1, lock_p2, toggle_beep, game_over}, 32'd0);
    endtask

    task automatic hold(input logic [7:0] joy, input int n);
        in_hex_joy = joy;
        step(n);
        in_hex_joy = 8'hFF;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_hex_joy = 8'hFF; ans_key = 4'd1;
        step(2);
        chk_all_zero("reset_state");
        reset = 1'b0;
        step(1);
        chk_all_zero("idle_after_reset");

        // Simultaneous presses after reset: P1 has priority
        pulse_start();
        ans_key = 4'd1;
        hold(8'h77, 6);
        chk("tie1_score_p1", score_p1, 1);
        chk("tie1_score_p2", score_p2, 0);
        chk("tie1_winner", round_winner, 1);
        step(8);
        chk("tie1_q_advance", q_index, 1);

        // Second tie with P1 as last winner: P2 gets it
        hold(8'h77, 6);
        chk("tie2_score_p2", score_p2, 1);
        chk("tie2_score_p1", score_p1, 1);
        chk("tie2_winner", round_winner, 2);

        // Reset during RESULT overrides a simultaneous start
        step(2);
        reset = 1'b1; start = 1'b1;
        step(1);
        reset = 1'b0; start = 1'b0;
        chk_all_zero("reset_in_result");
        ans_key = 4'd2;
        hold(8'hBF, 6);
        step(2);
        chk("idle_ignores_press", score_p1, 0);

        // Single correct press: latency and RESULT length
        pulse_start();
        in_hex_joy = 8'hBF;
        step(4);
        chk("accept_edge_no_score", score_p1, 0);
        step(1);
        chk("judge_edge_no_score", score_p1, 0);
        step(1);
        chk("correct_score_p1", score_p1, 1);
        chk("correct_winner", round_winner, 1);
        chk("correct_q_hold", q_index, 0);
        in_hex_joy = 8'hFF;
        step(7);
        chk("result_last_winner", round_winner, 1);
        chk("result_last_q", q_index, 0);
        step(1);
        chk("result_exit_winner", round_winner, 0);
        chk("result_exit_q", q_index, 1);

        // Short P2 press (3 cycles) is never accepted
        hold(8'hFB, 3);
        step(6);
        chk("short_press_score", score_p2, 0);
        chk("short_press_lock", lock_p2, 0);

        // Both players answer wrong
        ans_key = 4'd3;
        hold(8'h7F, 6);
        chk("wrong_p1_lock", {lock_p1, lock_p2}, 2'b10);
        chk("wrong_p1_score", score_p1, 1);
        hold(8'hFE, 6);
        chk("wrong_both_locks", {lock_p1, lock_p2}, 2'b11);
        chk("wrong_both_winner", round_winner, 0);
        chk("wrong_both_score_p2", score_p2, 0);
        step(7);
        chk("wrong_locks_held", {lock_p1, lock_p2}, 2'b11);
        step(1);
        chk("wrong_locks_cleared", {lock_p1, lock_p2}, 2'b00);
        chk("wrong_q_advance", q_index, 2);

        // P1 climbs to WIN_SCORE
        ans_key = 4'd1;
        for (int i = 0; i < 3; i++) begin
            hold(8'h7F, 6);
            step(8);
        end
        chk("climb_score", score_p1, 4);
        hold(8'h7F, 6);
        chk("win_score", score_p1, 5);
        chk("win_beep_on", toggle_beep, 1);
        chk("win_q_frozen", q_index, 5);
        step(15);
        chk("beep_last_cycle", {toggle_beep, game_over}, 2'b10);
        step(1);
        chk("beep_done", {toggle_beep, game_over}, 2'b01);

        // DONE ignores presses, start restarts in ASK
        hold(8'h7F, 6);
        step(2);
        chk("done_score_frozen", score_p1, 5);
        chk("done_over", game_over, 1);
        pulse_start();
        chk("restart_state", {q_index, score_p1, score_p2, game_over}, 0);

        // P2 reaches WIN, then reset mid-beep
        ans_key = 4'd4;
        for (int i = 0; i < 4; i++) begin
            hold(8'hFE, 6);
            step(8);
        end
        hold(8'hFE, 6);
        chk("p2_win_score", score_p2, 5);
        chk("p2_win_beep", toggle_beep, 1);
        step(3);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk_all_zero("reset_in_win");

        // Full game, nobody ever correct
        pulse_start();
        ans_key = 4'd2;
        for (int i = 0; i < 10; i++) begin
            hold(8'h7F, 6);
            hold(8'hFE, 6);
            step(8);
        end
        chk("full_game_over", game_over, 1);
        chk("full_game_q", q_index, 9);
        chk("full_game_scores", {score_p1, score_p2}, 0);
        step(3);
        chk("full_game_q_frozen", q_index, 9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
